// File: rtl/switch_cell_seg.sv
// ============================================================================
// Module   : switch_cell_seg
// Purpose  : Ingress cell segmenter: packs frame bytes into 128-bit words,
//            four words per 64-byte cell, then writes one cell pointer word.
//            Optional macro SWITCH_CELL_SEG_STATS_EN adds frame/trunc counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module switch_cell_seg #(
    parameter int MAX_CELLS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    input  logic [3:0]   s_portmap,
    output logic         s_ready,
    output logic [127:0] cell_data_fifo_din,
    output logic         cell_data_fifo_wr,
    output logic [15:0]  cell_ptr_fifo_din,
    output logic         cell_ptr_fifo_wr,
`ifdef SWITCH_CELL_SEG_STATS_EN
    output logic [15:0]  stat_frames,
    output logic [15:0]  stat_trunc,
`endif
    input  logic         cell_bp
);

    localparam logic [5:0] c_MAX_CELLS = 6'(MAX_CELLS);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_FILL = 3'd1;
    localparam logic [2:0] c_HOLD = 3'd2;
    localparam logic [2:0] c_PAD  = 3'd3;
    localparam logic [2:0] c_DROP = 3'd4;
    localparam logic [2:0] c_PTR  = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [3:0]   byte_idx_q;
    logic [1:0]   word_idx_q;
    logic [5:0]   cell_cnt_q;
    logic [127:0] pack_q;
    logic [3:0]   portmap_q;
    logic [127:0] data_q;
    logic         data_wr_q;
    logic [15:0]  ptr_q;
    logic         ptr_wr_q;

    logic         w_fill_acc;
    logic         w_word_done;
    logic         w_first;
    logic [5:0]   w_cnt_inc;
    logic [127:0] w_packed;

    assign w_fill_acc  = (state_q == c_FILL) && s_valid;
    assign w_word_done = w_fill_acc && ((byte_idx_q == 4'hF) || s_last);
    assign w_first     = (cell_cnt_q == 6'd0) && (word_idx_q == 2'd0) && (byte_idx_q == 4'd0);
    assign w_cnt_inc   = cell_cnt_q + 6'd1;
    // First byte of a word lands in the MSBs.
    assign w_packed    = pack_q | ({s_data, 120'b0} >> {byte_idx_q, 3'b000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: if (!cell_bp) state_d = c_FILL;
            c_FILL: begin
                if (w_word_done) begin
                    if (s_last) begin
                        state_d = (word_idx_q != 2'd3) ? c_PAD : c_PTR;
                    end else if (word_idx_q == 2'd3) begin
                        if (w_cnt_inc == c_MAX_CELLS) begin
                            state_d = c_DROP;
                        end else if (cell_bp) begin
                            state_d = c_HOLD;
                        end
                    end
                end
            end
            c_HOLD: if (!cell_bp) state_d = c_FILL;
            c_PAD:  if (word_idx_q == 2'd3) state_d = c_PTR;
            c_DROP: if (s_valid && s_last) state_d = c_PTR;
            c_PTR:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_q == c_FILL) || (state_q == c_DROP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_q <= 4'd0;
            word_idx_q <= 2'd0;
            cell_cnt_q <= 6'd0;
            pack_q     <= 128'd0;
            portmap_q  <= 4'd0;
            data_q     <= 128'd0;
            data_wr_q  <= 1'b0;
            ptr_q      <= 16'd0;
            ptr_wr_q   <= 1'b0;
        end else begin
            data_wr_q <= 1'b0;
            ptr_wr_q  <= 1'b0;
            case (state_q)
                c_FILL: begin
                    if (w_fill_acc) begin
                        if (w_first) portmap_q <= s_portmap;
                        if (w_word_done) begin
                            data_q     <= w_packed;
                            data_wr_q  <= 1'b1;
                            pack_q     <= 128'd0;
                            byte_idx_q <= 4'd0;
                            word_idx_q <= word_idx_q + 2'd1;
                            if (word_idx_q == 2'd3) cell_cnt_q <= w_cnt_inc;
                        end else begin
                            pack_q     <= w_packed;
                            byte_idx_q <= byte_idx_q + 4'd1;
                        end
                    end
                end
                c_PAD: begin
                    data_q     <= 128'd0;
                    data_wr_q  <= 1'b1;
                    word_idx_q <= word_idx_q + 2'd1;
                    if (word_idx_q == 2'd3) cell_cnt_q <= w_cnt_inc;
                end
                c_PTR: begin
                    ptr_q      <= {4'b0000, portmap_q, 2'b00, cell_cnt_q};
                    ptr_wr_q   <= 1'b1;
                    cell_cnt_q <= 6'd0;
                    word_idx_q <= 2'd0;
                    byte_idx_q <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign cell_data_fifo_din = data_q;
    assign cell_data_fifo_wr  = data_wr_q;
    assign cell_ptr_fifo_din  = ptr_q;
    assign cell_ptr_fifo_wr   = ptr_wr_q;

`ifdef SWITCH_CELL_SEG_STATS_EN
    logic [15:0] stat_frames_q;
    logic [15:0] stat_trunc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames_q <= 16'd0;
            stat_trunc_q  <= 16'd0;
        end else begin
            if ((state_q == c_PTR) && (stat_frames_q != 16'hFFFF))
                stat_frames_q <= stat_frames_q + 16'd1;
            if ((state_d == c_DROP) && (state_q != c_DROP) && (stat_trunc_q != 16'hFFFF))
                stat_trunc_q <= stat_trunc_q + 16'd1;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_trunc  = stat_trunc_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire
